eip_arbiter: RTL

- Platform-level external-interrupt arbiter: collects NSRC peripheral interrupt lines and funnels them onto the single m_eip / m_eip_reply handshake of the CSR/privilege unit.
- Software reaches it through a small memory-mapped register window: pending, enable, claim, complete.
- One interrupt is in service at a time; sources are chosen round-robin.

---
 rtl/eip_arbiter_if.sv | 14 +
 rtl/eip_arbiter.sv | 62 ++++++
 2 files changed

// File: rtl/eip_arbiter_if.sv
// eip_arbiter_if: register window, interrupt lines and eip handshake of the external-interrupt arbiter
interface eip_arbiter_if #(parameter int NSRC = 8);
  logic [NSRC-1:0] irq_src;
  logic [3:0] a;
  logic [31:0] d;
  logic we;
  logic rd;
  logic [31:0] spo;
  logic m_eip;
  logic m_eip_reply;
  logic busy;
  modport slave (input irq_src, a, d, we, rd, m_eip_reply, output spo, m_eip, busy);
  modport master (output irq_src, a, d, we, rd, m_eip_reply, input spo, m_eip, busy);
endinterface

// File: rtl/eip_arbiter.sv
// eip_arbiter: round-robin arbiter funnelling NSRC edge-triggered interrupts onto one eip handshake
module eip_arbiter #(parameter int NSRC = 8) (
  input logic clk,
  input logic rst,
  eip_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE, DONE} state_t;
  state_t state, state_n;
  logic [NSRC-1:0] src_q, pend, enable, req, clr;
  logic [4:0] win_id, last, pick;
  logic [1:0] sel;
  logic claimed, claim_rd, complete_ok, m_eip;
  logic unused;
  assign unused = ^{bus.a[1:0], bus.d[31:5]};
  assign sel = bus.a[3:2];
  assign req = pend & enable;
  assign claim_rd = bus.rd && sel == 2'd2 && state == SERVICE;
  assign complete_ok = bus.we && sel == 2'd3 && state == SERVICE && claimed && bus.d[4:0] == win_id;
  assign clr = claim_rd ? {{(NSRC-1){1'b0}}, 1'b1} << (win_id - 5'd1) : '0;
  assign bus.m_eip = m_eip;
  assign bus.busy = state != IDLE;
  assign bus.spo = sel == 2'd0 ? 32'(pend) : sel == 2'd1 ? 32'(enable) :
                   (sel == 2'd2 && state == SERVICE) ? 32'(win_id) : 32'd0;
  // round-robin search: first requesting index at or after last+1, wrapping; yields an ID (index+1)
  always_comb begin
    pick = '0;
    for (int k = NSRC - 1; k >= 0; k--)
      if (req[(int'(last) + 1 + k) % NSRC]) pick = 5'((int'(last) + 1 + k) % NSRC + 1);
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next state: grant, wait for acknowledge, wait for a valid complete, one guard cycle
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = |req ? ASSERT : IDLE;
      ASSERT:  state_n = bus.m_eip_reply ? SERVICE : ASSERT;
      SERVICE: state_n = complete_ok ? DONE : SERVICE;
      default: state_n = IDLE;
    endcase
  end
  // edge capture, registers, winner bookkeeping and the registered request line
  always_ff @(posedge clk)
    if (rst) begin
      src_q <= '0;
      pend <= '0;
      enable <= '0;
      win_id <= '0;
      last <= 5'(NSRC - 1);
      claimed <= 1'b0;
      m_eip <= 1'b0;
    end else begin
      src_q <= bus.irq_src;
      pend <= (pend & ~clr) | (bus.irq_src & ~src_q);
      if (bus.we && sel == 2'd1) enable <= bus.d[NSRC-1:0];
      if (state == IDLE && |req) win_id <= pick;
      if (state == ASSERT && bus.m_eip_reply) last <= win_id - 5'd1;
      claimed <= claim_rd | (claimed & ~complete_ok);
      m_eip <= state == ASSERT && !bus.m_eip_reply;
    end
endmodule
